prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 5 +
 rtl/prog_loader.sv | 69 ++++++
 tb/tb_prog_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: FSM state encoding and instruction data width shared by the loader
package prog_loader_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams an instruction image into external memory, then releases core reset
//   in_valid/in_data/in_last/in_ready : upstream word stream (ready only while loading)
//   mem_we/mem_addr/mem_wdata         : instruction-memory write port, driven in the handshake cycle
//   core_rst (active-low), done       : core released and loader finished, both only in RUN
//   overflow                          : sticky, image ran past the last memory word
//   checksum                          : modulo-2^32 sum of written words, only with PROG_LOADER_CHECKSUM_EN
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              overflow
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYCLES - 1);
  state_t            state, state_n;
  logic [ADDR_W-1:0] wptr;
  logic [7:0]        hold_cnt;
  logic              hs, at_end;
  // Outputs are masked by rst so they read as reset values during the rst cycle itself.
  assign in_ready  = !rst && state == LOAD;
  assign hs        = in_valid && in_ready;
  assign at_end    = wptr == LAST_ADDR;
  assign mem_we    = hs;
  assign mem_addr  = wptr;
  assign mem_wdata = in_data;
  assign core_rst  = !rst && state == RUN;
  assign done      = core_rst;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? LOAD :
              state == LOAD ? (hs && (in_last || at_end) ? HOLD : LOAD) :
              state == HOLD ? (hold_cnt == HOLD_LAST ? RUN : HOLD) : RUN;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // wptr saturates at the last word; a further word there ends the load as an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      hold_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (hs && !at_end) wptr <= wptr + 1'b1;
      if (hs && at_end && !in_last) overflow <= 1'b1;
      if (state == HOLD) hold_cnt <= hold_cnt + 8'd1;
    end
  end
`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk)
    checksum <= rst ? '0 : hs ? checksum + in_data : checksum;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed scoreboard bench for prog_loader (ADDR_W=8 and ADDR_W=2 instances)
module tb_prog_loader;
  import prog_loader_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, rst_b = 1'b1;
  logic        a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, a_we, a_crst, a_done, a_ovf;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_ready, b_we, b_crst, b_done, b_ovf;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  int          n_chk = 0, n_fail = 0;
  logic [39:0] exp_q[$];
  logic [31:0] words[3] = '{32'h00500293, 32'h00A00313, 32'h006283B3};
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] a_sum, b_sum;
`endif
  prog_loader #(.ADDR_W(8), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
    .in_ready(a_ready), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .core_rst(a_crst), .done(a_done), .overflow(a_ovf)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .checksum(a_sum)
`endif
  );
  prog_loader #(.ADDR_W(2), .HOLD_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .in_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .core_rst(b_crst), .done(b_done), .overflow(b_ovf)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .checksum(b_sum)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_a(input logic v, input logic [31:0] d, input logic l);
    a_valid = v;
    a_data  = d;
    a_last  = l;
  endtask
  task automatic write_a(input logic [7:0] addr, input logic [31:0] d, input logic l);
    drive_a(1'b1, d, l);
    exp_q.push_back({addr, d});
    @(negedge clk);
    chk("load_we", 40'(a_we), 40'd1);
    tick;
  endtask
  task automatic reset_a;
    rst = 1'b1;
    drive_a(1'b0, '0, 1'b0);
    tick;
    @(negedge clk);
    chk("rst_outputs", 40'({a_ready, a_we, a_crst, a_done, a_ovf}), 40'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 40'(a_ready), 40'd0);
    tick;
  endtask
  task automatic hold_then_run(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 40'({a_crst, a_done, a_ready, a_we}), 40'd0);
      tick;
    end
    @(negedge clk);
    chk({tag, "_run"}, 40'({a_crst, a_done}), 40'd3);
  endtask
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      chk("write_expected", 40'(exp_q.size() != 0), 40'd1);
      if (exp_q.size() != 0) chk("write_addr_data", {a_addr, a_wdata}, exp_q.pop_front());
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("por_outputs", 40'({a_ready, a_we, a_crst, a_done, a_ovf}), 40'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 40'(a_ready), 40'd0);
    tick;
    for (int i = 0; i < 3; i++) write_a(8'(i), words[i], i == 2);
    drive_a(1'b0, '0, 1'b0);
    hold_then_run("t1");
    chk("t1_ovf", 40'(a_ovf), 40'd0);
    drive_a(1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("run_ignore", 40'({a_we, a_ready, a_done, a_crst}), 40'b0011);
      tick;
    end
    reset_a;
    write_a(8'd0, 32'h11111111, 1'b0);
    drive_a(1'b0, 32'h99999999, 1'b0);
    @(negedge clk);
    chk("t2_gap", 40'(a_we), 40'd0);
    tick;
    write_a(8'd1, 32'h22222222, 1'b1);
    drive_a(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("t2_hold_crst", 40'({a_crst, a_ready}), 40'd0);
    tick;
    rst = 1'b1;
    @(negedge clk);
    chk("t3_rst_crst", 40'({a_crst, a_done}), 40'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("t3_idle", 40'({a_crst, a_ready}), 40'd0);
    tick;
    write_a(8'd0, 32'h33333333, 1'b1);
    drive_a(1'b0, '0, 1'b0);
    hold_then_run("t3");
`ifdef PROG_LOADER_CHECKSUM_EN
    reset_a;
    chk("sum_clear", 40'(a_sum), 40'd0);
    write_a(8'd0, 32'hFFFFFFFF, 1'b0);
    write_a(8'd1, 32'h00000002, 1'b1);
    drive_a(1'b1, 32'h12345678, 1'b0);
    hold_then_run("sum");
    chk("sum_value", 40'(a_sum), 40'd1);
    drive_a(1'b0, '0, 1'b0);
`endif
    rst_b = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1;
      b_data  = 32'hB000_0000 + 32'(i);
      b_last  = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        chk("b_write", 40'({b_ready, b_we, b_addr, b_wdata}), 40'({2'b11, 2'(i), b_data}));
        chk("b_ovf_pre", 40'(b_ovf), 40'd0);
      end else begin
        chk("b_5th_blocked", 40'({b_ready, b_we}), 40'd0);
      end
      tick;
    end
    b_valid = 1'b0;
    @(negedge clk);
    chk("b_ovf", 40'({b_ovf, b_crst}), 40'b10);
    chk("sb_empty", 40'(exp_q.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
